// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - RV32I funct3 encodings for the width/extension field
//  - FSM state type
//  - alignment / legality helpers used at request accept
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_ADDR,
        S_LD_DATA,
        S_RMW_ADDR,
        S_RMW_MERGE,
        S_ST_WRITE,
        S_RESP,
        S_ERR_RESP
    } lsu_state_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic lsu_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return !(funct3 inside {F3_B, F3_H, F3_W});
        return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core/memory-side bus of the load/store unit.
//  req_*  : one load/store per valid/ready handshake
//  resp_* : one-cycle completion pulse with load data and error flag
//  mem_*  : word-wide memory, registered 1-cycle read, full-word write
// Modports: slave = the unit, master = the core + memory environment.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_error;
    logic [31:0]           resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_write;
    logic [31:0]           mem_writedata;
    logic [31:0]           mem_readword;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_readword,
        output req_ready, resp_valid, resp_error, resp_rdata,
               mem_address, mem_write, mem_writedata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_readword,
        input  req_ready, resp_valid, resp_error, resp_rdata,
               mem_address, mem_write, mem_writedata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (combinational).
//  word_i   : word read from memory
//  wdata_i  : store data (low byte/half used for SB/SH)
//  funct3_i : access width / extension
//  lane_i   : addr[1:0] of the access
//  rdata_o  : extracted and extended load result
//  merged_o : word with the store lane replaced (wdata_i for SW)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = word_i[{lane_i, 3'b000} +: 8];
        half_w = word_i[{lane_i[1], 4'b0000} +: 16];

        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_w[7]}}, byte_w};
            F3_H:    rdata_o = {{16{half_w[15]}}, half_w};
            F3_BU:   rdata_o = {24'd0, byte_w};
            F3_HU:   rdata_o = {16'd0, half_w};
            default: rdata_o = word_i;
        endcase

        merged_o = word_i;
        case (funct3_i[1:0])
            2'b00:   merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            2'b01:   merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load/store per handshake and runs the
// memory cycles for it. Sub-word stores are read-modify-write because the
// memory only writes whole words.
//  clock, reset_n : clock, synchronous active-low reset
//  bus            : request/response/memory bus (slave view)
// All resp_* and mem_* outputs are registered; they are computed from the
// transition being taken so they line up with the state they belong to.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    lsu_state_t            state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_write_q, mem_write_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [31:0]           ld_rdata, st_merged;
    logic                  req_bad;

    lsu_align u_align (
        .word_i   (bus.mem_readword),
        .wdata_i  (wdata_q),
        .funct3_i (funct3_q),
        .lane_i   (lane_q),
        .rdata_o  (ld_rdata),
        .merged_o (st_merged)
    );

    assign req_bad = lsu_illegal(bus.req_write, bus.req_funct3) ||
                     lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]);

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_write_d  = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    lane_d   = bus.req_addr[1:0];
                    wdata_d  = bus.req_wdata;
                    if (req_bad) begin
                        // No memory access: mem_address keeps its old value.
                        state_d      = S_ERR_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        mem_addr_d = bus.req_addr[ADDR_WIDTH-1:0];
                        if (!bus.req_write) begin
                            state_d = S_LD_ADDR;
                        end else if (bus.req_funct3 == F3_W) begin
                            state_d     = S_ST_WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            state_d = S_RMW_ADDR;
                        end
                    end
                end
            end
            S_LD_ADDR:   state_d = S_LD_DATA;
            S_LD_DATA: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = ld_rdata;
            end
            S_RMW_ADDR:  state_d = S_RMW_MERGE;
            S_RMW_MERGE: begin
                state_d     = S_ST_WRITE;
                mem_write_d = 1'b1;
                mem_wdata_d = st_merged;
            end
            S_ST_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'd0;
            end
            S_RESP, S_ERR_RESP: state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            funct3_q     <= '0;
            lane_q       <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_error    = resp_error_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_address   = mem_addr_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_writedata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory behind the unit, byte-array
// reference model for expected results, directed cases then random traffic.
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    load_store_unit_if #(.ADDR_WIDTH(10)) bus ();

    load_store_unit #(.ADDR_WIDTH(10)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Memory: registered read, whole-word write, reset blocks the write.
    logic [31:0] mem [0:255] = '{default: 32'd0};
    always @(posedge clock) begin
        if (reset_n && bus.mem_write)
            mem[bus.mem_address[9:2]] <= bus.mem_writedata;
        bus.mem_readword <= mem[bus.mem_address[9:2]];
    end

    // Reference model: byte-addressed memory image.
    logic [7:0] ref_mem [0:1023] = '{default: 8'd0};

    int n_chk = 0;
    int n_fail = 0;
    int mw_total = 0;
    int exp_writes = 0;

    always @(negedge clock) if (bus.mem_write) mw_total++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        int          sz, e_lat, lat, nwr, wr_k, t;
        logic [9:0]  a10;
        logic        legal, e_err, got_err;
        logic [31:0] e_rd, e_word, prev_addr, wr_addr, wr_data;
        a10   = a[9:0];
        sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e_err = !legal || (int'(a10) % sz != 0);
        e_lat = e_err ? 1 : (!w ? 3 : (f3 == 3'd2 ? 2 : 4));
        e_rd  = 32'd0;
        e_word = 32'd0;
        if (!e_err && !w) begin
            for (int i = 0; i < sz; i++) e_rd[8*i +: 8] = ref_mem[int'(a10) + i];
            if (!f3[2] && sz == 1) e_rd = {{24{e_rd[7]}}, e_rd[7:0]};
            if (!f3[2] && sz == 2) e_rd = {{16{e_rd[15]}}, e_rd[15:0]};
        end
        if (!e_err && w) begin
            for (int i = 0; i < sz; i++) ref_mem[int'(a10) + i] = wd[8*i +: 8];
            for (int i = 0; i < 4; i++) e_word[8*i +: 8] = ref_mem[int'({a10[9:2], 2'b00}) + i];
            exp_writes++;
        end

        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("accept", 32'(bus.req_ready), 32'd1);
        prev_addr = 32'(bus.mem_address);

        lat = 0; nwr = 0; wr_k = 0; wr_addr = 0; wr_data = 0; got_err = 1'b0; rd = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 1) begin
                // Garbage request held valid: must be ignored until IDLE.
                bus.req_write  = 1'($urandom);
                bus.req_funct3 = 3'($urandom);
                bus.req_addr   = $urandom;
                bus.req_wdata  = $urandom;
                if (e_err) chk("err_addr_hold", 32'(bus.mem_address), prev_addr);
            end
            if (bus.mem_write) begin
                nwr++;
                wr_k    = k;
                wr_addr = 32'(bus.mem_address);
                wr_data = bus.mem_writedata;
            end
            if (bus.resp_valid) begin
                lat     = k;
                rd      = bus.resp_rdata;
                got_err = bus.resp_error;
                break;
            end
        end
        chk("latency", lat, e_lat);
        chk("resp_error", 32'(got_err), 32'(e_err));
        chk("resp_rdata", rd, e_rd);
        chk("mem_write_cnt", nwr, (!e_err && w) ? 1 : 0);
        if (!e_err && w) begin
            chk("wr_cycle", wr_k, e_lat - 1);
            chk("wr_addr", wr_addr, 32'(a10));
            chk("wr_data", wr_data, e_word);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [8:0]  rdy;
        int          nresp, seen_rv, seen_mw, mw_before;
        logic [31:0] a, wd;
        logic [2:0]  f3;
        logic        w;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        // Reset held two cycles.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_writedata", bus.mem_writedata, 32'd0);
        chk("rst_no_write", mw_total, 0);
        reset_n = 1'b1;

        // Word store/load.
        do_req(1'b1, 3'b010, 32'h008, 32'hDEADBEEF, rd);
        do_req(1'b0, 3'b010, 32'h008, 32'h0, rd);
        chk("lw_008", rd, 32'hDEADBEEF);

        // Byte RMW and byte loads.
        do_req(1'b1, 3'b000, 32'h009, 32'h00000055, rd);
        do_req(1'b0, 3'b000, 32'h009, 32'h0, rd);
        chk("lb_009", rd, 32'h00000055);
        do_req(1'b0, 3'b000, 32'h00B, 32'h0, rd);
        chk("lb_00b", rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h00B, 32'h0, rd);
        chk("lbu_00b", rd, 32'h000000DE);

        // Half RMW and half loads.
        do_req(1'b1, 3'b001, 32'h00A, 32'h12348001, rd);
        do_req(1'b0, 3'b001, 32'h00A, 32'h0, rd);
        chk("lh_00a", rd, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h00A, 32'h0, rd);
        chk("lhu_00a", rd, 32'h00008001);
        do_req(1'b0, 3'b010, 32'h008, 32'h0, rd);
        chk("lw_after_sh", rd, 32'h800155EF);

        // Error cases.
        do_req(1'b0, 3'b010, 32'h006, 32'h0, rd);
        do_req(1'b1, 3'b001, 32'h003, 32'hFFFFFFFF, rd);
        do_req(1'b0, 3'b011, 32'h008, 32'h0, rd);
        do_req(1'b0, 3'b010, 32'h008, 32'h0, rd);
        chk("lw_after_err", rd, 32'h800155EF);

        // Reset during RMW_MERGE of an SB.
        mw_before = mw_total;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h008;
        bus.req_wdata  = 32'h000000AA;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
        reset_n = 1'b1;
        seen_rv = 0;
        seen_mw = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.resp_valid) seen_rv++;
            if (bus.mem_write) seen_mw++;
        end
        chk("rstmid_no_resp", seen_rv, 0);
        chk("rstmid_no_write", seen_mw + (mw_total - mw_before), 0);
        do_req(1'b0, 3'b010, 32'h008, 32'h0, rd);
        chk("lw_after_rst", rd, 32'h800155EF);

        // req_valid held high: accepts only in IDLE, every 4 cycles for LW.
        nresp = 0;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h008;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clock);
            rdy[k] = bus.req_ready;
            if (bus.resp_valid) begin
                nresp++;
                chk("b2b_rdata", bus.resp_rdata, 32'h800155EF);
            end
            if (k == 8) bus.req_valid = 1'b0;
        end
        chk("b2b_ready", 32'(rdy), 32'h111);
        chk("b2b_resp", nresp, 2);

        // Random traffic, clustered in the low words with random high bits.
        for (int n = 0; n < 200; n++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 47));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
            wd = $urandom;
            do_req(w, f3, a, wd, rd);
        end

        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 16; i++)
            chk("mem_image", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
        chk("write_total", mw_total, exp_writes);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
